// File: rtl/video_crtc_prog_pkg.sv
// Shared timing constants and helpers for the programmable CRTC.
// Holds the 640x400@70 and 640x480@60 timing sets and sync polarities.
package video_crtc_prog_pkg;

  localparam int unsigned H_VIS_400  = 640;
  localparam int unsigned H_FP_400   = 16;
  localparam int unsigned H_SYNC_400 = 96;
  localparam int unsigned H_BP_400   = 48;
  localparam int unsigned V_VIS_400  = 400;
  localparam int unsigned V_FP_400   = 12;
  localparam int unsigned V_SYNC_400 = 2;
  localparam int unsigned V_BP_400   = 35;
  localparam bit          HS_POL_400 = 1'b0;
  localparam bit          VS_POL_400 = 1'b1;

  localparam int unsigned H_VIS_480  = 640;
  localparam int unsigned H_FP_480   = 16;
  localparam int unsigned H_SYNC_480 = 96;
  localparam int unsigned H_BP_480   = 48;
  localparam int unsigned V_VIS_480  = 480;
  localparam int unsigned V_FP_480   = 10;
  localparam int unsigned V_SYNC_480 = 2;
  localparam int unsigned V_BP_480   = 33;
  localparam bit          HS_POL_480 = 1'b0;
  localparam bit          VS_POL_480 = 1'b0;

  function automatic int unsigned axis_total(int unsigned vis, int unsigned fp,
                                             int unsigned sync, int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_crtc_prog_if.sv
// Register/video bus between the adapter control logic and the CRTC.
// The master owns the programming registers; the slave (CRTC) drives the video timing outputs.
interface video_crtc_prog_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DA_W   = 4
);
  logic [ADDR_W-1:0] iStartAddr;
  logic [ADDR_W-1:0] iStride;
  logic [3:0]        iGlyphMaxY;
  logic              iCursorEn;
  logic [ADDR_W-1:0] iCursorAddr;
  logic [3:0]        iCursorStart;
  logic [3:0]        iCursorEnd;

  logic [ADDR_W-1:0] oAddr;
  logic [3:0]        oRA;
  logic [DA_W-1:0]   oDA;
  logic              oBlank;
  logic              oHs;
  logic              oVs;
  logic              oCursor;
  logic              oBlinkPhase;
  logic              oVRetrace;
  logic              oFrameStart;

  modport master (
    output iStartAddr, iStride, iGlyphMaxY, iCursorEn, iCursorAddr, iCursorStart, iCursorEnd,
    input  oAddr, oRA, oDA, oBlank, oHs, oVs, oCursor, oBlinkPhase, oVRetrace, oFrameStart
  );

  modport slave (
    input  iStartAddr, iStride, iGlyphMaxY, iCursorEn, iCursorAddr, iCursorStart, iCursorEnd,
    output oAddr, oRA, oDA, oBlank, oHs, oVs, oCursor, oBlinkPhase, oVRetrace, oFrameStart
  );
endinterface

// File: rtl/video_crtc_prog_sync_axis.sv
// One timing axis: wrapping counter with visible-region and sync-pulse decode.
// Used once per pixel (horizontal) and once per line (vertical).
module video_crtc_prog_sync_axis
  import video_crtc_prog_pkg::*;
#(
  parameter int unsigned Vis  = 640,
  parameter int unsigned Fp   = 16,
  parameter int unsigned Sync = 96,
  parameter int unsigned Bp   = 48,
  parameter bit          Pol  = 1'b0,
  parameter int unsigned CntW = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  output logic [CntW-1:0] cnt_o,
  output logic            wrap_o,
  output logic            vis_o,
  output logic            sync_o
);
  localparam int unsigned Total = axis_total(Vis, Fp, Sync, Bp);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign wrap_o = en_i & (cnt_q == CntW'(Total - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign vis_o  = cnt_q < CntW'(Vis);
  assign sync_o = (cnt_q >= CntW'(Vis + Fp) && cnt_q < CntW'(Vis + Fp + Sync)) ? Pol : ~Pol;
endmodule

// File: rtl/video_crtc_prog.sv
// Register-programmable CRTC: sync/blank timing, per-frame scroll base, row stride,
// glyph height and blinking hardware cursor, all outputs registered one cycle after the counters.
module video_crtc_prog
  import video_crtc_prog_pkg::*;
#(
  parameter int unsigned H_VIS       = H_VIS_400,
  parameter int unsigned H_FP        = H_FP_400,
  parameter int unsigned H_SYNC      = H_SYNC_400,
  parameter int unsigned H_BP        = H_BP_400,
  parameter int unsigned V_VIS       = V_VIS_400,
  parameter int unsigned V_FP        = V_FP_400,
  parameter int unsigned V_SYNC      = V_SYNC_400,
  parameter int unsigned V_BP        = V_BP_400,
  parameter bit          HS_POL      = HS_POL_400,
  parameter bit          VS_POL      = VS_POL_400,
  parameter int unsigned CHAR_W_LOG2 = 3,
  parameter int unsigned V_DOUBLE    = 1,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned BLINK_LOG2  = 3
) (
  input  logic             iClk25,
  input  logic             iRst,
  video_crtc_prog_if.slave bus
);
  localparam int unsigned HTotal = axis_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = axis_total(V_VIS, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);
  localparam int unsigned RepW   = (V_DOUBLE > 0) ? V_DOUBLE : 1;
  localparam int unsigned RepMax = (1 << V_DOUBLE) - 1;
  localparam int unsigned FcW    = BLINK_LOG2 + 1;
  localparam int unsigned DaW    = CHAR_W_LOG2 + 1;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, h_vis, h_sync;
  logic          v_wrap, v_vis, v_sync;

  video_crtc_prog_sync_axis #(
    .Vis(H_VIS), .Fp(H_FP), .Sync(H_SYNC), .Bp(H_BP), .Pol(HS_POL), .CntW(HW)
  ) u_h_axis (
    .clk_i (iClk25),
    .rst_i (iRst),
    .en_i  (1'b1),
    .cnt_o (h_cnt),
    .wrap_o(h_wrap),
    .vis_o (h_vis),
    .sync_o(h_sync)
  );

  // v_wrap only fires on the last pixel of the last line, so it doubles as frame end.
  video_crtc_prog_sync_axis #(
    .Vis(V_VIS), .Fp(V_FP), .Sync(V_SYNC), .Bp(V_BP), .Pol(VS_POL), .CntW(VW)
  ) u_v_axis (
    .clk_i (iClk25),
    .rst_i (iRst),
    .en_i  (h_wrap),
    .cnt_o (v_cnt),
    .wrap_o(v_wrap),
    .vis_o (v_vis),
    .sync_o(v_sync)
  );

  logic [ADDR_W-1:0] row_addr_d, row_addr_q;
  logic [3:0]        ra_d, ra_q;
  logic [RepW-1:0]   rep_d, rep_q;
  logic [FcW-1:0]    frame_cnt_d, frame_cnt_q;

  always_comb begin
    row_addr_d  = row_addr_q;
    ra_d        = ra_q;
    rep_d       = rep_q;
    frame_cnt_d = frame_cnt_q;
    if (v_wrap) begin
      row_addr_d  = bus.iStartAddr;
      ra_d        = '0;
      rep_d       = '0;
      frame_cnt_d = frame_cnt_q + 1'b1;
    end else if (h_wrap) begin
      if (rep_q == RepW'(RepMax)) begin
        rep_d = '0;
        // >= so a glyph height shrunk below the current row wraps immediately.
        if (ra_q >= bus.iGlyphMaxY) begin
          ra_d       = '0;
          row_addr_d = row_addr_q + bus.iStride;
        end else begin
          ra_d = ra_q + 1'b1;
        end
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [3:0]        ra_out_d, ra_out_q;
  logic [DaW-1:0]    da_d, da_q;
  logic              blank_d, blank_q, hs_d, hs_q, vs_d, vs_q;
  logic              cursor_d, cursor_q, blink_d, blink_q;
  logic              vretrace_d, vretrace_q, fstart_d, fstart_q;

  always_comb begin
    addr_d     = row_addr_q + ADDR_W'(h_cnt >> CHAR_W_LOG2);
    ra_out_d   = ra_q;
    da_d       = h_cnt[DaW-1:0];
    blank_d    = ~(h_vis & v_vis);
    hs_d       = h_sync;
    vs_d       = v_sync;
    blink_d    = frame_cnt_q[BLINK_LOG2];
    cursor_d   = bus.iCursorEn & blink_d & (addr_d == bus.iCursorAddr) &
                 (ra_q >= bus.iCursorStart) & (ra_q <= bus.iCursorEnd);
    vretrace_d = ~v_vis;
    fstart_d   = (h_cnt == '0) && (v_cnt == '0);
  end

  // Reset loads the scroll base like a frame end, so a restart matches a normal frame.
  always_ff @(posedge iClk25) begin
    if (iRst) begin
      row_addr_q  <= bus.iStartAddr;
      ra_q        <= '0;
      rep_q       <= '0;
      frame_cnt_q <= '0;
      addr_q      <= '0;
      ra_out_q    <= '0;
      da_q        <= '0;
      blank_q     <= 1'b1;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      cursor_q    <= 1'b0;
      blink_q     <= 1'b0;
      vretrace_q  <= 1'b0;
      fstart_q    <= 1'b0;
    end else begin
      row_addr_q  <= row_addr_d;
      ra_q        <= ra_d;
      rep_q       <= rep_d;
      frame_cnt_q <= frame_cnt_d;
      addr_q      <= addr_d;
      ra_out_q    <= ra_out_d;
      da_q        <= da_d;
      blank_q     <= blank_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      cursor_q    <= cursor_d;
      blink_q     <= blink_d;
      vretrace_q  <= vretrace_d;
      fstart_q    <= fstart_d;
    end
  end

  assign bus.oAddr       = addr_q;
  assign bus.oRA         = ra_out_q;
  assign bus.oDA         = da_q;
  assign bus.oBlank      = blank_q;
  assign bus.oHs         = hs_q;
  assign bus.oVs         = vs_q;
  assign bus.oCursor     = cursor_q;
  assign bus.oBlinkPhase = blink_q;
  assign bus.oVRetrace   = vretrace_q;
  assign bus.oFrameStart = fstart_q;
endmodule

// File: tb/tb_video_crtc_prog.sv
// Bench for video_crtc_prog on a shrunken 80x47 timing: directed vectors, frame sequences
// and randomized frames, every pixel compared against a closed-form per-frame model.
module tb_video_crtc_prog;
  localparam int unsigned HV = 64, HF = 4, HSY = 8, HB = 4;
  localparam int unsigned VV = 40, VF = 2, VSY = 2, VB = 3;
  localparam int HT = 80, VT = 47, FT = HT * VT;
  localparam int unsigned AW = 13, VD = 1, BL = 1, CW = 3;
  localparam bit HP = 1'b0, VP = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_crtc_prog_if #(.ADDR_W(AW), .DA_W(CW + 1)) bus ();

  video_crtc_prog #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .CHAR_W_LOG2(CW), .V_DOUBLE(VD),
    .ADDR_W(AW), .BLINK_LOG2(BL)
  ) dut (
    .iClk25(clk),
    .iRst  (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [12:0] addr;
    logic [3:0]  ra;
    logic [3:0]  da;
    logic        blank, hs, vs, cur, blink, vret, fs;
  } obs_t;

  typedef struct {
    int start, stride, gm, cen, caddr, cs, ce;
  } cfg_t;

  typedef struct {
    int h, v, addr, ra, da, blank, hs, vs, vret;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   kcur  = -1;
  int   pend_start = 0;
  cfg_t fcfg;
  vec_t tbl[14];

  function automatic obs_t model(int k, cfg_t c);
    obs_t m;
    int h, v, f, lpr, crow, a, ra;
    h    = k % HT;
    v    = (k / HT) % VT;
    f    = k / FT;
    lpr  = (c.gm + 1) << VD;
    crow = v / lpr;
    ra   = (v >> VD) % (c.gm + 1);
    a    = (c.start + crow * c.stride + (h >> CW)) & 32'h1FFF;
    m.addr  = 13'(a);
    m.ra    = 4'(ra);
    m.da    = 4'(h % 16);
    m.blank = (h >= int'(HV)) || (v >= int'(VV));
    m.hs    = (h >= int'(HV + HF) && h < int'(HV + HF + HSY)) ? HP : ~HP;
    m.vs    = (v >= int'(VV + VF) && v < int'(VV + VF + VSY)) ? VP : ~VP;
    m.blink = ((f >> BL) & 1) == 1;
    m.cur   = (c.cen != 0) && m.blink && (a == c.caddr) && (ra >= c.cs) && (ra <= c.ce);
    m.vret  = v >= int'(VV);
    m.fs    = (h == 0) && (v == 0);
    return m;
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s.addr  = bus.oAddr;
    s.ra    = bus.oRA;
    s.da    = bus.oDA;
    s.blank = bus.oBlank;
    s.hs    = bus.oHs;
    s.vs    = bus.oVs;
    s.cur   = bus.oCursor;
    s.blink = bus.oBlinkPhase;
    s.vret  = bus.oVRetrace;
    s.fs    = bus.oFrameStart;
    return s;
  endfunction

  function automatic int cur_h();
    return kcur % HT;
  endfunction

  function automatic int cur_v();
    return (kcur / HT) % VT;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (h=%0d v=%0d)", name, act, exp, cur_h(),
               cur_v());
    end
  endtask

  // Advance one pixel and compare the whole output vector with the model.
  task automatic tick();
    int   kn;
    obs_t e, a;
    kn = kcur + 1;
    if (kn % FT == 0) begin
      fcfg.start  = pend_start;
      fcfg.stride = int'(bus.iStride);
      fcfg.gm     = int'(bus.iGlyphMaxY);
      fcfg.cen    = int'(bus.iCursorEn);
      fcfg.caddr  = int'(bus.iCursorAddr);
      fcfg.cs     = int'(bus.iCursorStart);
      fcfg.ce     = int'(bus.iCursorEnd);
    end
    if (kn % FT == FT - 1) pend_start = int'(bus.iStartAddr);
    @(negedge clk);
    kcur = kn;
    e = model(kn, fcfg);
    a = sample();
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL model h=%0d v=%0d: got %h expected %h", cur_h(), cur_v(), a, e);
    end
  endtask

  task automatic goto(input int h, input int v);
    int n = 0;
    while (!(cur_h() == h && cur_v() == v) && n <= FT) begin
      tick();
      n++;
    end
    if (!(cur_h() == h && cur_v() == v)) chk("goto_timeout", n, -1);
  endtask

  task automatic do_reset();
    obs_t r;
    rst = 1'b1;
    pend_start = int'(bus.iStartAddr);
    @(negedge clk);
    r = '0;
    r.blank = 1'b1;
    r.hs    = ~HP;
    r.vs    = ~VP;
    chk("reset_outputs", int'(sample()), int'(r));
    rst  = 1'b0;
    kcur = -1;
  endtask

  task automatic count_frame(output int n_fs, output int n_hs, output int n_vs,
                             output int n_cur, output int a0);
    n_fs = 0; n_hs = 0; n_vs = 0; n_cur = 0; a0 = 0;
    for (int i = 0; i < FT; i++) begin
      tick();
      if (i == 0) a0 = int'(bus.oAddr);
      n_fs  += int'(bus.oFrameStart);
      n_hs  += int'(bus.oHs == HP);
      n_vs  += int'(bus.oVs == VP);
      n_cur += int'(bus.oCursor);
    end
  endtask

  task automatic rand_frame();
    int mid;
    mid = int'($urandom_range(1, FT - 3));
    bus.iStride      = 13'($urandom_range(0, 300));
    bus.iGlyphMaxY   = 4'($urandom_range(0, 15));
    bus.iCursorEn    = 1'($urandom_range(0, 3) != 0);
    bus.iCursorAddr  = 13'(pend_start + int'($urandom_range(0, 20)));
    bus.iCursorStart = 4'($urandom_range(0, 15));
    bus.iCursorEnd   = 4'($urandom_range(0, 15));
    for (int i = 0; i < FT; i++) begin
      tick();
      if (i == mid) bus.iStartAddr = 13'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_fs, n_hs, n_vs, n_cur, a0;
    tbl[0]  = '{67, 0,   8, 0,  3, 1, 1, 0, 0};
    tbl[1]  = '{68, 0,   8, 0,  4, 1, 0, 0, 0};
    tbl[2]  = '{75, 0,   9, 0, 11, 1, 0, 0, 0};
    tbl[3]  = '{76, 0,   9, 0, 12, 1, 1, 0, 0};
    tbl[4]  = '{63, 15,  7, 7, 15, 0, 1, 0, 0};
    tbl[5]  = '{64, 15,  8, 7,  0, 1, 1, 0, 0};
    tbl[6]  = '{0,  16, 80, 0,  0, 0, 1, 0, 0};
    tbl[7]  = '{5,  39, 160, 3, 5, 0, 1, 0, 0};
    tbl[8]  = '{0,  40, 160, 4, 0, 1, 1, 0, 1};
    tbl[9]  = '{0,  41, 160, 4, 0, 1, 1, 0, 1};
    tbl[10] = '{0,  42, 160, 5, 0, 1, 1, 1, 1};
    tbl[11] = '{0,  43, 160, 5, 0, 1, 1, 1, 1};
    tbl[12] = '{0,  44, 160, 6, 0, 1, 1, 0, 1};
    tbl[13] = '{79, 46, 169, 7, 15, 1, 1, 0, 1};

    bus.iStartAddr   = '0;
    bus.iStride      = 13'd80;
    bus.iGlyphMaxY   = 4'd7;
    bus.iCursorEn    = 1'b1;
    bus.iCursorAddr  = 13'd5;
    bus.iCursorStart = 4'd6;
    bus.iCursorEnd   = 4'd7;
    do_reset();

    // Frame 0: directed pixels; the scroll base changes mid-frame and must not tear.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].v >= 20) bus.iStartAddr = 13'h100;
      goto(tbl[i].h, tbl[i].v);
      chk("tbl_addr",  int'(bus.oAddr),     tbl[i].addr);
      chk("tbl_ra",    int'(bus.oRA),       tbl[i].ra);
      chk("tbl_da",    int'(bus.oDA),       tbl[i].da);
      chk("tbl_blank", int'(bus.oBlank),    tbl[i].blank);
      chk("tbl_hs",    int'(bus.oHs),       tbl[i].hs);
      chk("tbl_vs",    int'(bus.oVs),       tbl[i].vs);
      chk("tbl_vret",  int'(bus.oVRetrace), tbl[i].vret);
    end

    // Frame 1: scrolled base, sync widths and single frame-start pulse.
    bus.iStartAddr = 13'h1FF8;
    count_frame(n_fs, n_hs, n_vs, n_cur, a0);
    chk("scroll_addr", a0, 'h100);
    chk("frame_start_count", n_fs, 1);
    chk("hs_active_count", n_hs, int'(HSY) * VT);
    chk("vs_active_count", n_vs, int'(VSY) * HT);
    chk("cursor_phase0_count", n_cur, 0);

    // Frame 2: address arithmetic wraps modulo 2^13.
    goto(0, 0);
    chk("wrap_base", int'(bus.oAddr), 'h1FF8);
    goto(64, 0);
    chk("wrap_addr", int'(bus.oAddr), 0);
    bus.iStartAddr = '0;
    goto(HT - 1, VT - 1);

    // Frame 3: blink phase on, cursor rows 6..7 of char 5 in row 0.
    count_frame(n_fs, n_hs, n_vs, n_cur, a0);
    chk("cursor_count", n_cur, 32);

    rand_frame();
    rand_frame();

    // Frame 6: inverted cursor range gives no cursor; frame 7 restores it.
    bus.iStride      = 13'd80;
    bus.iGlyphMaxY   = 4'd7;
    bus.iCursorEn    = 1'b1;
    bus.iCursorAddr  = 13'd5;
    bus.iCursorStart = 4'd7;
    bus.iCursorEnd   = 4'd6;
    bus.iStartAddr   = '0;
    count_frame(n_fs, n_hs, n_vs, n_cur, a0);
    chk("cursor_inverted_count", n_cur, 0);
    bus.iCursorStart = 4'd6;
    bus.iCursorEnd   = 4'd7;
    count_frame(n_fs, n_hs, n_vs, n_cur, a0);
    chk("cursor_count_f7", n_cur, 32);

    // Mid-frame reset restarts at (0,0) with the base sampled during reset.
    goto(30, 10);
    bus.iStartAddr = 13'hABC;
    do_reset();
    tick();
    chk("restart_fs", int'(bus.oFrameStart), 1);
    chk("restart_da", int'(bus.oDA), 0);
    chk("restart_addr", int'(bus.oAddr), 'hABC);
    chk("restart_blink", int'(bus.oBlinkPhase), 0);
    goto(HT - 1, VT - 1);

    for (int i = 0; i < 3; i++) rand_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
